// File: rtl/rf_writeback_arbiter.sv
// Register-file writeback arbiter: accepts one VLIW bundle of slot results, drops
// same-address losers (highest slot wins) and drains survivors over N_WP write ports.
module rf_writeback_arbiter #(
    parameter int N_SLOTS = 10,
    parameter int N_WP    = 2,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [N_SLOTS-1:0]          in_we,
    input  logic [N_SLOTS*ADDR_W-1:0]   in_waddr,
    input  logic [N_SLOTS*DATA_W-1:0]   in_wdata,
    output logic [N_WP-1:0]             rf_we,
    output logic [N_WP*ADDR_W-1:0]      rf_waddr,
    output logic [N_WP*DATA_W-1:0]      rf_wdata,
    output logic                        stall,
    output logic [7:0]                  conflict_cnt
);

    localparam int CW = $clog2(N_SLOTS + 1);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                      state_q, state_d;
    logic [N_SLOTS-1:0]          pending_q, pending_d;
    logic [N_SLOTS*ADDR_W-1:0]   addr_q, addr_d;
    logic [N_SLOTS*DATA_W-1:0]   data_q, data_d;
    logic [7:0]                  conflict_cnt_q, conflict_cnt_d;
    logic [N_SLOTS-1:0]          keep, grant, avail;
    logic                        found;
    logic                        accept;

    function automatic logic [CW-1:0] popcount(input logic [N_SLOTS-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < N_SLOTS; i++) c = c + CW'(v[i]);
        return c;
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [CW-1:0] b);
        logic [8:0] s;
        s = {1'b0, a} + 9'(b);
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    // An enabled slot survives only if no higher-index enabled slot targets the same register.
    always_comb begin
        keep = in_we;
        for (int i = 0; i < N_SLOTS; i++) begin
            for (int j = i + 1; j < N_SLOTS; j++) begin
                if (in_we[i] && in_we[j] &&
                    in_waddr[i*ADDR_W +: ADDR_W] == in_waddr[j*ADDR_W +: ADDR_W])
                    keep[i] = 1'b0;
            end
        end
    end

    // Port k takes the k-th lowest pending slot; unused ports drive zeros.
    always_comb begin
        grant    = '0;
        rf_we    = '0;
        rf_waddr = '0;
        rf_wdata = '0;
        found    = 1'b0;
        avail    = (state_q == DRAIN) ? pending_q : '0;
        for (int k = 0; k < N_WP; k++) begin
            found = 1'b0;
            for (int i = 0; i < N_SLOTS; i++) begin
                if (!found && avail[i]) begin
                    found    = 1'b1;
                    avail[i] = 1'b0;
                    grant[i] = 1'b1;
                    rf_we[k] = 1'b1;
                    rf_waddr[k*ADDR_W +: ADDR_W] = addr_q[i*ADDR_W +: ADDR_W];
                    rf_wdata[k*DATA_W +: DATA_W] = data_q[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign in_ready     = (state_q == IDLE) || (popcount(pending_q) <= CW'(N_WP));
    assign accept       = in_valid && in_ready;
    assign stall        = in_valid && !in_ready;
    assign conflict_cnt = conflict_cnt_q;

    always_comb begin
        state_d        = state_q;
        pending_d      = pending_q;
        addr_d         = addr_q;
        data_d         = data_q;
        conflict_cnt_d = conflict_cnt_q;
        if (state_q == DRAIN) begin
            pending_d = pending_q & ~grant;
            if (pending_d == '0) state_d = IDLE;
        end
        // Accepting overrides drain retirement: in_ready guarantees the old bundle finishes now.
        if (accept) begin
            addr_d         = in_waddr;
            data_d         = in_wdata;
            pending_d      = keep;
            conflict_cnt_d = sat_add(conflict_cnt_q, popcount(in_we) - popcount(keep));
            state_d        = (keep != '0) ? DRAIN : IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            pending_q      <= '0;
            conflict_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    // Payload copies need no reset: they are only observed through pending bits.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Scoreboard bench for rf_writeback_arbiter: directed bundles push expected port
// cycles into a queue; a negedge monitor pops and compares every active write cycle.
module tb_rf_writeback_arbiter;

    localparam int N_SLOTS = 10;
    localparam int N_WP    = 2;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       in_valid;
    logic                       in_ready;
    logic [N_SLOTS-1:0]         in_we;
    logic [N_SLOTS*ADDR_W-1:0]  in_waddr;
    logic [N_SLOTS*DATA_W-1:0]  in_wdata;
    logic [N_WP-1:0]            rf_we;
    logic [N_WP*ADDR_W-1:0]     rf_waddr;
    logic [N_WP*DATA_W-1:0]     rf_wdata;
    logic                       stall;
    logic [7:0]                 conflict_cnt;

    typedef struct packed {
        logic [1:0]  we;
        logic [9:0]  addr;
        logic [63:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_act, mon_exp;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    rf_writeback_arbiter #(
        .N_SLOTS(N_SLOTS), .N_WP(N_WP), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_we(in_we), .in_waddr(in_waddr), .in_wdata(in_wdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .stall(stall), .conflict_cnt(conflict_cnt)
    );

    always @(negedge clk) begin
        if (rf_we != '0) begin
            mon_act = {rf_we, rf_waddr, rf_wdata};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got %h, expected no write", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    n_fail++;
                    $display("FAIL rf_write: got %h, expected %h", mon_act, mon_exp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic clear_inputs();
        in_we    = '0;
        in_waddr = '0;
        in_wdata = '0;
    endtask

    task automatic set_slot(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        in_we[i] = 1'b1;
        in_waddr[i*ADDR_W +: ADDR_W] = a;
        in_wdata[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic push_exp(input logic [1:0] we, input logic [4:0] a0, input logic [31:0] d0,
                            input logic [4:0] a1, input logic [31:0] d1);
        exp_t e;
        e.we   = we;
        e.addr = {a1, a0};
        e.data = {d1, d0};
        exp_q.push_back(e);
    endtask

    // Returns 1 time unit after the accept edge with in_valid dropped.
    task automatic issue();
        int t;
        t = 0;
        in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t == 50) begin
            n_cmp++;
            n_fail++;
            $display("FAIL issue_timeout: in_ready stayed 0, expected 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        clear_inputs();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = 1'b0;
        clear_inputs();

        // Reset values, with a request present to exercise stall
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b1;
        #1;
        check("rst_rf_we", rf_we, 0);
        check("rst_rf_waddr", rf_waddr, 0);
        check("rst_rf_wdata", rf_wdata, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_stall", stall, 0);
        check("rst_conflict_cnt", conflict_cnt, 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Single write from slot 9
        set_slot(9, 5'd2, 32'd4);
        push_exp(2'b01, 5'd2, 32'd4, 5'd0, 32'd0);
        issue();
        check("single_ready", in_ready, 1);
        in_valid = 1'b1;
        #1;
        check("single_stall", stall, 0);
        in_valid = 1'b0;
        idle(3);

        // Five writes over three drain cycles
        set_slot(0, 5'd1, 32'd10);
        set_slot(2, 5'd2, 32'd20);
        set_slot(4, 5'd3, 32'd30);
        set_slot(6, 5'd4, 32'd40);
        set_slot(8, 5'd5, 32'd50);
        push_exp(2'b11, 5'd1, 32'd10, 5'd2, 32'd20);
        push_exp(2'b11, 5'd3, 32'd30, 5'd4, 32'd40);
        push_exp(2'b01, 5'd5, 32'd50, 5'd0, 32'd0);
        issue();
        check("five_ready_c1", in_ready, 0);
        in_valid = 1'b1;
        #1;
        check("five_stall_c1", stall, 1);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("five_ready_c2", in_ready, 0);
        @(posedge clk); #1;
        check("five_ready_c3", in_ready, 1);
        idle(3);

        // Same-address conflict inside one bundle
        set_slot(1, 5'd4, 32'hA);
        set_slot(7, 5'd4, 32'hB);
        push_exp(2'b01, 5'd4, 32'hB, 5'd0, 32'd0);
        issue();
        check("conflict_cnt_1", conflict_cnt, 1);
        idle(2);

        // 29 bundles of 9 conflicts each drive the counter into saturation
        for (int b = 0; b < 29; b++) begin
            for (int s = 0; s < N_SLOTS; s++) set_slot(s, 5'd7, 32'(b * 16 + s));
            push_exp(2'b01, 5'd7, 32'(b * 16 + 9), 5'd0, 32'd0);
            issue();
            if (b == 0) check("conflict_cnt_10", conflict_cnt, 10);
            if (b == 27) check("conflict_cnt_253", conflict_cnt, 253);
        end
        check("conflict_cnt_sat", conflict_cnt, 255);
        idle(3);

        // Back-to-back bundles, in_valid held high; address 0 is an ordinary target
        set_slot(0, 5'd0, 32'd100);
        set_slot(1, 5'd8, 32'd101);
        set_slot(2, 5'd9, 32'd102);
        push_exp(2'b11, 5'd0, 32'd100, 5'd8, 32'd101);
        push_exp(2'b01, 5'd9, 32'd102, 5'd0, 32'd0);
        push_exp(2'b11, 5'd10, 32'd200, 5'd11, 32'd201);
        push_exp(2'b01, 5'd12, 32'd202, 5'd0, 32'd0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        clear_inputs();
        set_slot(3, 5'd10, 32'd200);
        set_slot(5, 5'd11, 32'd201);
        set_slot(9, 5'd12, 32'd202);
        check("b2b_ready_c1", in_ready, 0);
        @(negedge clk);
        check("b2b_active_c1", rf_we != '0, 1);
        @(posedge clk); #1;
        check("b2b_ready_c2", in_ready, 1);
        @(negedge clk);
        check("b2b_active_c2", rf_we != '0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        clear_inputs();
        @(negedge clk);
        check("b2b_active_c3", rf_we != '0, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("b2b_active_c4", rf_we != '0, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("b2b_done", rf_we, 0);
        idle(2);

        // Reset during the second drain cycle of a full bundle
        for (int s = 0; s < N_SLOTS; s++) set_slot(s, 5'(20 + s), 32'(32'h1000 + s));
        push_exp(2'b11, 5'd20, 32'h1000, 5'd21, 32'h1001);
        issue();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_rf_we", rf_we, 0);
        check("rst_mid_cnt", conflict_cnt, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_mid_ready", in_ready, 1);
        idle(5);

        // Zero-write bundle followed immediately by a real one
        in_valid = 1'b1;
        #1;
        check("zero_ready", in_ready, 1);
        @(posedge clk); #1;
        check("zero_no_write", rf_we, 0);
        check("zero_ready_after", in_ready, 1);
        check("zero_cnt", conflict_cnt, 0);
        set_slot(0, 5'd3, 32'd33);
        push_exp(2'b01, 5'd3, 32'd33, 5'd0, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        clear_inputs();
        check("zero_next_accept", rf_we, 2'b01);
        idle(4);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
